// File: rtl/demux64_1x2_stream_if.sv
// Valid/ready stream bundle used for the demux input and both output channels.
// sel carries the destination on the input side; output channels tie it to their index.
interface demux64_1x2_stream_if #(
  parameter int unsigned DATA_W = 64
);
  logic [DATA_W-1:0] data;
  logic              sel;
  logic              valid;
  logic              ready;

  modport master (output data, output sel, output valid, input ready);
  modport slave  (input data, input sel, input valid, output ready);
endinterface

// File: rtl/demux64_1x2_stream.sv
// Registered 1-to-2 valid/ready stream demultiplexer with a one-entry register per channel.
// Optional per-channel delivery counters are built only when DEMUX_COUNT_EN is defined.
module demux64_1x2_stream #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned COUNT_W = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  demux64_1x2_stream_if.slave       i_in,
  demux64_1x2_stream_if.master      o_out0,
  demux64_1x2_stream_if.master      o_out1,
  output logic [COUNT_W-1:0]        o_cnt0,
  output logic [COUNT_W-1:0]        o_cnt1
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  state_e            r_state     [2];
  state_e            w_state_nxt [2];
  logic [DATA_W-1:0] r_data      [2];
  logic [1:0]        w_out_ready;
  logic [1:0]        w_full;
  logic [1:0]        w_accept;
  logic [1:0]        w_deliver;
  logic [1:0]        w_load;
  logic              w_in_ready_c;

  assign w_out_ready = {o_out1.ready, o_out0.ready};

  // Ready looks only at the channel the current word is headed for.
  assign w_in_ready_c = i_rst_n && (!w_full[i_in.sel] || w_out_ready[i_in.sel]);
  assign i_in.ready   = w_in_ready_c;

  always_comb begin
    w_full    = '0;
    w_accept  = '0;
    w_deliver = '0;
    for (int n = 0; n < 2; n++) begin
      w_full[n]    = (r_state[n] == ST_FULL);
      w_accept[n]  = i_in.valid && w_in_ready_c && (i_in.sel == 1'(n));
      w_deliver[n] = w_full[n] && w_out_ready[n];
    end
  end

  // State register: channel occupancy and held word.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int n = 0; n < 2; n++) begin
        r_state[n] <= ST_EMPTY;
        r_data[n]  <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        r_state[n] <= w_state_nxt[n];
        if (w_load[n]) r_data[n] <= i_in.data;
      end
    end
  end

  // Next state: a delivery with a same-cycle refill stays FULL.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      w_state_nxt[n] = r_state[n];
      case (r_state[n])
        ST_EMPTY: if (w_accept[n])                  w_state_nxt[n] = ST_FULL;
        ST_FULL:  if (w_deliver[n] && !w_accept[n]) w_state_nxt[n] = ST_EMPTY;
        default:                                    w_state_nxt[n] = ST_EMPTY;
      endcase
    end
  end

  // Output decode: data register loads on every accept into that channel.
  always_comb begin
    w_load = '0;
    for (int n = 0; n < 2; n++) begin
      w_load[n] = w_accept[n];
    end
  end

  assign o_out0.data  = r_data[0];
  assign o_out0.valid = w_full[0];
  assign o_out0.sel   = 1'b0;
  assign o_out1.data  = r_data[1];
  assign o_out1.valid = w_full[1];
  assign o_out1.sel   = 1'b1;

`ifdef DEMUX_COUNT_EN
  logic [COUNT_W-1:0] r_cnt [2];

  // Delivery counters wrap naturally at 2**COUNT_W.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int n = 0; n < 2; n++) r_cnt[n] <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (w_deliver[n]) r_cnt[n] <= r_cnt[n] + COUNT_W'(1);
      end
    end
  end

  assign o_cnt0 = r_cnt[0];
  assign o_cnt1 = r_cnt[1];
`else
  assign o_cnt0 = '0;
  assign o_cnt1 = '0;
`endif

endmodule

// File: tb/tb_demux64_1x2_stream.sv
// Scoreboard bench for demux64_1x2_stream: directed stimulus pushes expected words,
// a negedge monitor pops and compares every delivery per channel.
module tb_demux64_1x2_stream;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 4;
`ifdef DEMUX_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [CW-1:0] cnt0, cnt1;
  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  demux64_1x2_stream_if #(.DATA_W(DW)) s_in ();
  demux64_1x2_stream_if #(.DATA_W(DW)) s_out0 ();
  demux64_1x2_stream_if #(.DATA_W(DW)) s_out1 ();

  demux64_1x2_stream #(.DATA_W(DW), .COUNT_W(CW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_in    (s_in),
    .o_out0  (s_out0),
    .o_out1  (s_out1),
    .o_cnt0  (cnt0),
    .o_cnt1  (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] exp_cnt(input int v);
    return CNT_EN ? DW'(v % (1 << CW)) : '0;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a posedge; returns just after the edge that accepted the word.
  task automatic send(input logic [DW-1:0] d, input logic s);
    int budget;
    budget = 0;
    s_in.valid = 1'b1;
    s_in.data  = d;
    s_in.sel   = s;
    forever begin
      @(negedge clk);
      if (s_in.ready === 1'b1) break;
      budget++;
      if (budget > 50) begin
        n_chk++;
        n_fail++;
        $display("FAIL send_timeout: got ready=0 expected ready=1 within 50 cycles");
        break;
      end
    end
    if (s) q1.push_back(d); else q0.push_back(d);
    @(posedge clk);
    #1;
    s_in.valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every delivery must match the oldest expected word of that channel.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (s_out0.valid === 1'b1 && s_out0.ready === 1'b1) begin
        n_chk++;
        if (q0.size() == 0) begin
          n_fail++;
          $display("FAIL sb_out0: got unexpected word %0h expected none", s_out0.data);
        end else begin
          logic [DW-1:0] e;
          e = q0.pop_front();
          if (s_out0.data !== e) begin
            n_fail++;
            $display("FAIL sb_out0: got %0h expected %0h", s_out0.data, e);
          end
        end
      end
      if (s_out1.valid === 1'b1 && s_out1.ready === 1'b1) begin
        n_chk++;
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL sb_out1: got unexpected word %0h expected none", s_out1.data);
        end else begin
          logic [DW-1:0] e;
          e = q1.pop_front();
          if (s_out1.data !== e) begin
            n_fail++;
            $display("FAIL sb_out1: got %0h expected %0h", s_out1.data, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    rst_n        = 1'b0;
    s_in.valid   = 1'b1;
    s_in.data    = 64'h1234;
    s_in.sel     = 1'b0;
    s_out0.ready = 1'b1;
    s_out1.ready = 1'b1;

    // 1. Reset with valid input: nothing accepted, outputs cleared
    idle(2);
    chk("rst_in_ready", DW'(s_in.ready), 0);
    chk("rst_v0", DW'(s_out0.valid), 0);
    chk("rst_v1", DW'(s_out1.valid), 0);
    chk("rst_d0", s_out0.data, 0);
    chk("rst_d1", s_out1.data, 0);
    chk("rst_cnt0", DW'(cnt0), 0);
    chk("rst_cnt1", DW'(cnt1), 0);
    s_in.valid = 1'b0;
    rst_n = 1'b1;
    idle(1);

    // 2. Routing and one-cycle latency
    send(64'd4294967294, 1'b0);
    chk("route_v0", DW'(s_out0.valid), 1);
    chk("route_d0", s_out0.data, 64'd4294967294);
    send(64'd4294967295, 1'b1);
    chk("route_v0_gone", DW'(s_out0.valid), 0);
    chk("route_v1", DW'(s_out1.valid), 1);
    chk("route_d1", s_out1.data, 64'd4294967295);
    idle(1);
    chk("route_v1_gone", DW'(s_out1.valid), 0);

    // 3. Backpressure on channel 0
    s_out0.ready = 1'b0;
    send(64'hAAAA_0000_0000_000A, 1'b0);
    s_in.valid = 1'b1;
    s_in.data  = 64'hBBBB_0000_0000_000B;
    s_in.sel   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", DW'(s_in.ready), 0);
      chk("bp_hold_d0", s_out0.data, 64'hAAAA_0000_0000_000A);
    end
    @(posedge clk);
    #1;
    s_out0.ready = 1'b1;
    send(64'hBBBB_0000_0000_000B, 1'b0);
    chk("bp_b_loaded", s_out0.data, 64'hBBBB_0000_0000_000B);
    idle(2);
    chk("bp_q0_empty", DW'(q0.size()), 0);

    // 4. Channel 1 streams at full rate while channel 0 is stalled
    s_out0.ready = 1'b0;
    send(64'hC0DE, 1'b0);
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(DW'(64'h100 + i), 1'b1);
    chk("ind_throughput", DW'(cyc - t0), 8);
    idle(2);
    chk("ind_q1_empty", DW'(q1.size()), 0);
    chk("ind_hold_v0", DW'(s_out0.valid), 1);
    chk("ind_hold_d0", s_out0.data, 64'hC0DE);
    chk("ind_cnt0", DW'(cnt0), exp_cnt(3));
    chk("ind_cnt1", DW'(cnt1), exp_cnt(9));

    // 5. Reset while both channels hold a word
    s_out1.ready = 1'b0;
    send(64'hD00D, 1'b1);
    chk("mid_full1", DW'(s_out1.valid), 1);
    rst_n = 1'b0;
    idle(1);
    chk("mid_v0", DW'(s_out0.valid), 0);
    chk("mid_v1", DW'(s_out1.valid), 0);
    chk("mid_cnt0", DW'(cnt0), 0);
    q0.delete();
    q1.delete();
    rst_n = 1'b1;
    s_out0.ready = 1'b1;
    s_out1.ready = 1'b1;
    idle(1);
    send(64'h1, 1'b1);
    chk("mid_new_d1", s_out1.data, 64'h1);
    idle(2);
    chk("mid_q1_empty", DW'(q1.size()), 0);
    chk("mid_v0_idle", DW'(s_out0.valid), 0);
    chk("mid_cnt1", DW'(cnt1), exp_cnt(1));

    // 6. Counter wrap on channel 0 (COUNT_W=4)
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) send(DW'(64'h200 + i), 1'b0);
    idle(2);
    chk("cnt0_15", DW'(cnt0), exp_cnt(15));
    for (int i = 15; i < 17; i++) send(DW'(64'h200 + i), 1'b0);
    idle(2);
    chk("cnt0_wrap", DW'(cnt0), exp_cnt(17));
    chk("cnt1_zero", DW'(cnt1), 0);
    chk("end_q0_empty", DW'(q0.size()), 0);
    chk("end_q1_empty", DW'(q1.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
